mcpu_memio_capture: RTL

Sits directly downstream of the MCPU core's memory output port and upstream of its memory input port. It is the bridge between the core and the simulation top or board logic.
- Captures each 32-bit word the core emits into a small FIFO.
- Presents the captured words to a host over a valid/ready handshake.
- Holds a registered input word that drives the core's meminput.
- Counts words dropped on overflow, so lost output is visible instead of silently discarded.

---
 rtl/mcpu_memio_capture_if.sv | 34 +++
 rtl/mcpu_memio_capture.sv | 88 ++++++++
 2 files changed

// File: rtl/mcpu_memio_capture_if.sv
// Core/host-facing signal bundle of the memory I/O capture bridge.
// slave = bridge side, master = core and host side.
interface mcpu_memio_capture_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH_LOG2     = 3,
    parameter int DROP_CNT_WIDTH = 16
);
    logic [DATA_WIDTH-1:0]     core_memoutput;
    logic                      core_memoutput_we;
    logic [DATA_WIDTH-1:0]     core_meminput;
    logic [DATA_WIDTH-1:0]     host_in_data;
    logic                      host_in_load;
    logic [DATA_WIDTH-1:0]     host_out_data;
    logic                      host_out_valid;
    logic                      host_out_ready;
    logic [DEPTH_LOG2:0]       fifo_count;
    logic                      overflow;
    logic [DROP_CNT_WIDTH-1:0] dropped_count;
    logic                      overflow_clr;

    modport slave (
        input  core_memoutput, core_memoutput_we, host_in_data, host_in_load,
               host_out_ready, overflow_clr,
        output core_meminput, host_out_data, host_out_valid, fifo_count,
               overflow, dropped_count
    );

    modport master (
        output core_memoutput, core_memoutput_we, host_in_data, host_in_load,
               host_out_ready, overflow_clr,
        input  core_meminput, host_out_data, host_out_valid, fifo_count,
               overflow, dropped_count
    );
endinterface

// File: rtl/mcpu_memio_capture.sv
// Captures core output words into a FIFO for the host (1-cycle latency); words strobed
// while full with no pop are dropped and counted; core meminput is a host-loaded register.
module mcpu_memio_capture #(
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH_LOG2     = 3,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                    clkrst_core_clk,
    input  logic                    clkrst_core_rst,
    mcpu_memio_capture_if.slave     bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);

    logic [DATA_WIDTH-1:0]     r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0]     r_rd_ptr;
    logic [DEPTH_LOG2-1:0]     r_wr_ptr;
    logic [DEPTH_LOG2:0]       r_count;
    logic                      r_overflow;
    logic [DROP_CNT_WIDTH-1:0] r_drop_cnt;
    logic [DATA_WIDTH-1:0]     r_meminput;

    logic w_valid;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_valid = (r_count != '0);
    assign w_full  = (r_count == FULL_CNT);
    assign w_pop   = w_valid && bus.host_out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the word.
    assign w_push  = bus.core_memoutput_we && (!w_full || w_pop);
    assign w_drop  = bus.core_memoutput_we && w_full && !w_pop;

    always_ff @(posedge clkrst_core_clk) begin
        if (w_push && !clkrst_core_rst) begin
            r_mem[r_wr_ptr] <= bus.core_memoutput;
        end
    end

    always_ff @(posedge clkrst_core_clk) begin
        if (clkrst_core_rst) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
            r_meminput <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end

            // A drop coinciding with a clear restarts the tally at one.
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (bus.overflow_clr) begin
                    r_drop_cnt <= DROP_CNT_WIDTH'(1);
                end else if (r_drop_cnt != '1) begin
                    r_drop_cnt <= r_drop_cnt + 1'b1;
                end
            end else if (bus.overflow_clr) begin
                r_overflow <= 1'b0;
                r_drop_cnt <= '0;
            end

            if (bus.host_in_load) begin
                r_meminput <= bus.host_in_data;
            end
        end
    end

    assign bus.host_out_valid = w_valid;
    assign bus.host_out_data  = r_mem[r_rd_ptr];
    assign bus.fifo_count     = r_count;
    assign bus.overflow       = r_overflow;
    assign bus.dropped_count  = r_drop_cnt;
    assign bus.core_meminput  = r_meminput;
endmodule
